// File: rtl/gcd_operand_queue.sv
// Operand staging FIFO in front of the GCD engine: buffers (x,y) jobs, reports occupancy and issued-job count.
// Build option GCD_ZERO_GUARD_EN rewrites x==0 pairs on enqueue so the engine never sees (0,y!=0).
module gcd_operand_queue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_x,
    output logic [WIDTH-1:0]         out_y,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_WIDTH-1:0]     issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0]     mem_x [DEPTH];
    logic [WIDTH-1:0]     mem_y [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic [CNT_WIDTH-1:0] issued_q;
    logic                 enq;
    logic                 deq;
    logic [2*WIDTH-1:0]   wr_pair;

    function automatic logic [2*WIDTH-1:0] guard_pair(input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
`ifdef GCD_ZERO_GUARD_EN
        // (0,y) becomes (y,0): the engine then returns y, and (0,0) returns 0.
        if (x == '0)
            return {y, {WIDTH{1'b0}}};
        else
            return {x, y};
`else
        return {x, y};
`endif
    endfunction

    // Reset is folded in so producers see a stalled queue while it is held.
    assign in_ready  = reset & (count_q != CW'(DEPTH)) & ~flush;
    assign out_valid = (count_q != '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign out_x     = mem_x[rd_ptr];
    assign out_y     = mem_y[rd_ptr];
    assign count     = count_q;
    assign issued    = issued_q;
    assign wr_pair   = guard_pair(in_x, in_y);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A dequeue completes even in a flush cycle, so the job counter ignores flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            issued_q <= '0;
        else if (deq)
            issued_q <= issued_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_x[wr_ptr] <= wr_pair[2*WIDTH-1:WIDTH];
            mem_y[wr_ptr] <= wr_pair[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_gcd_operand_queue.sv
// Directed bench for gcd_operand_queue: table of vectors plus hand sequences for full, wrap, flush and reset.
module tb_gcd_operand_queue;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = 16;

`ifdef GCD_ZERO_GUARD_EN
    localparam logic [31:0] GX = 32'd12;
    localparam logic [31:0] GY = 32'd0;
`else
    localparam logic [31:0] GX = 32'd0;
    localparam logic [31:0] GY = 32'd12;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  in_x = '0;
    logic [W-1:0]  in_y = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_x;
    logic [W-1:0]  out_y;
    logic [2:0]    count;
    logic [CW-1:0] issued;

    gcd_operand_queue #(.WIDTH(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .count(count), .issued(issued)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [31:0] ix;
        logic [31:0] iy;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        erdy;
        logic [31:0] ex;
        logic [31:0] ey;
        logic [2:0]  ecnt;
        logic [15:0] eiss;
    } vec_t;

    vec_t        tbl [9];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] q [$];
    logic [15:0] exp_iss = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] stored(input logic [31:0] x, input logic [31:0] y);
`ifdef GCD_ZERO_GUARD_EN
        if (x == 32'd0)
            return {y, 32'd0};
`endif
        return {x, y};
    endfunction

    // Checks outputs against the queue model before the edge, then advances model and clock.
    task automatic tick(input string nm, input bit check);
        logic do_enq;
        logic do_deq;
        @(negedge clock);
        do_enq = in_valid && (q.size() != D) && !flush;
        do_deq = out_ready && (q.size() != 0);
        if (check) begin
            chk({nm, ".count"}, 64'(count), 64'(q.size()));
            chk({nm, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
            chk({nm, ".in_ready"}, 64'(in_ready), 64'((q.size() != D) && !flush));
            chk({nm, ".issued"}, 64'(issued), 64'(exp_iss));
            if (q.size() != 0) begin
                chk({nm, ".out_x"}, 64'(out_x), 64'(q[0][63:32]));
                chk({nm, ".out_y"}, 64'(out_y), 64'(q[0][31:0]));
            end
        end
        if (do_deq) begin
            void'(q.pop_front());
            exp_iss++;
        end
        if (flush)
            q.delete();
        else if (do_enq)
            q.push_back(stored(in_x, in_y));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 32'd48,  32'd18, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0,   32'd0,  3'd0, 16'd0};
        tbl[1] = '{1'b1, 32'd7,   32'd5,  1'b1, 1'b0, 1'b1, 1'b1, 32'd48,  32'd18, 3'd1, 16'd0};
        tbl[2] = '{1'b1, 32'd100, 32'd75, 1'b1, 1'b0, 1'b1, 1'b1, 32'd7,   32'd5,  3'd1, 16'd1};
        tbl[3] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 32'd100, 32'd75, 3'd1, 16'd2};
        tbl[4] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'd0,   32'd0,  3'd0, 16'd3};
        tbl[5] = '{1'b1, 32'd0,   32'd12, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0,   32'd0,  3'd0, 16'd3};
        tbl[6] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b1, 1'b1, GX,      GY,     3'd1, 16'd3};
        tbl[7] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b0, 1'b1, 1'b1, GX,      GY,     3'd1, 16'd3};
        tbl[8] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'd0,   32'd0,  3'd0, 16'd4};

        repeat (3) @(posedge clock);
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.issued", 64'(issued), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            in_valid  = tbl[i].iv;
            in_x      = tbl[i].ix;
            in_y      = tbl[i].iy;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            @(negedge clock);
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(tbl[i].ecnt));
            chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].erdy));
            chk($sformatf("vec%0d.issued", i), 64'(issued), 64'(tbl[i].eiss));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d.out_x", i), 64'(out_x), 64'(tbl[i].ex));
                chk($sformatf("vec%0d.out_y", i), 64'(out_y), 64'(tbl[i].ey));
            end
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_iss   = 16'd4;

        // Full: five pushes with a stalled consumer, only four land.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 32'(i + 1);
            in_y     = 32'(i + 11);
            tick("full_push", 1'b1);
        end
        chk("full.count", 64'(count), 64'd4);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        in_x      = 32'd99;
        in_y      = 32'd99;
        out_ready = 1'b1;
        tick("full_deq", 1'b1);
        chk("full_deq.count", 64'(count), 64'd3);
        in_valid = 1'b0;
        tick("drain", 1'b1);

        // Wrap: concurrent traffic at count=2 walks the pointers round twice.
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_x = 32'(200 + k);
            in_y = 32'(300 + k);
            tick("wrap", 1'b1);
        end
        chk("wrap.count", 64'(count), 64'd2);
        in_x = 32'd5;
        in_y = 32'd3;
        for (int k = 0; k < 70000 && exp_iss != 16'hFFFF; k++)
            tick("stream", 1'b0);
        chk("iss_max", 64'(issued), 64'hFFFF);
        tick("iss_wrap", 1'b1);
        chk("iss_wrap.issued", 64'(issued), 64'd0);

        // Flush: one dequeue still counts, enqueue is blocked.
        out_ready = 1'b0;
        tick("pre_flush", 1'b1);
        chk("pre_flush.count", 64'(count), 64'd3);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick("flush", 1'b1);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.issued", 64'(issued), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick("post_flush", 1'b1);

        // Reset mid-traffic with three entries held.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = 32'(40 + i);
            in_y = 32'(50 + i);
            tick("pre_rst", 1'b1);
        end
        in_valid = 1'b0;
        chk("pre_rst.count", 64'(count), 64'd3);
        reset = 1'b0;
        #2;
        chk("rst2.count", 64'(count), 64'd0);
        chk("rst2.out_valid", 64'(out_valid), 64'd0);
        chk("rst2.issued", 64'(issued), 64'd0);
        chk("rst2.in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        chk("rst2_hold.count", 64'(count), 64'd0);
        reset = 1'b1;
        q.delete();
        exp_iss = '0;
        tick("post_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
